// File: rtl/s_inv_2x2_pkg.sv
// ---------------------------------------------------------------------------
// s_inv_2x2_pkg
// Shared types and helpers for the 2x2 innovation-covariance inverter.
//   - s_inv_state_e : sequencing states of the inverter FSM
//   - BEAT_0..2     : out_beat index values, in the order the B_cache loader
//                     consumes them
//   - sat_reduce()  : reduces a wide signed result to w bits. Its body is
//                     selected by the S_INV_SAT_EN macro:
//                       defined   -> clamp to [-2^(w-1), 2^(w-1)-1]
//                       undefined -> keep the low w bits (wrap)
// ---------------------------------------------------------------------------
package s_inv_2x2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PROD,
    ST_DET,
    ST_DIV,
    ST_SCALE,
    ST_OUT0,
    ST_OUT1,
    ST_OUT2
  } s_inv_state_e;

  localparam logic [1:0] BEAT_0 = 2'd0;
  localparam logic [1:0] BEAT_1 = 2'd1;
  localparam logic [1:0] BEAT_2 = 2'd2;

  // Widest value sat_reduce() accepts; callers sign-extend into it.
  localparam int SAT_W = 128;

  function automatic logic signed [SAT_W-1:0] sat_reduce(
    input logic signed [SAT_W-1:0] x,
    input int unsigned             w
  );
`ifdef S_INV_SAT_EN
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_W'(1) << (w - 1)) - SAT_W'(1);
    lo = ~hi;  // == -hi - 1
    if (x > hi) return hi;
    else if (x < lo) return lo;
    else return x;
`else
    logic [SAT_W-1:0] mask;
    mask = (SAT_W'(1) << w) - SAT_W'(1);
    return x & mask;
`endif
  endfunction

endpackage

// File: rtl/s_inv_2x2_if.sv
// ---------------------------------------------------------------------------
// s_inv_2x2_if
// Bundle of the inverter's input handshake, S elements and output beat bus.
//   master : producer/consumer side (drives in_vld and S elements)
//   slave  : inverter side (drives in_rdy, beats, singular, busy)
// Signals:
//   in_vld/in_rdy          input handshake (accept when both high)
//   s_11, s_12, s_22       signed S elements, Q(RSA_DW-FRAC_W).FRAC_W
//   out_vld/out_beat       beat valid and beat index 0..2
//   out_dout               {lane1, lane0}, each RSA_DW wide
//   singular, busy         status
// ---------------------------------------------------------------------------
interface s_inv_2x2_if #(
  parameter int RSA_DW = 32
);
  logic                     in_vld;
  logic                     in_rdy;
  logic signed [RSA_DW-1:0] s_11;
  logic signed [RSA_DW-1:0] s_12;
  logic signed [RSA_DW-1:0] s_22;
  logic                     out_vld;
  logic [1:0]               out_beat;
  logic [2*RSA_DW-1:0]      out_dout;
  logic                     singular;
  logic                     busy;

  modport master (
    output in_vld, s_11, s_12, s_22,
    input  in_rdy, out_vld, out_beat, out_dout, singular, busy
  );

  modport slave (
    input  in_vld, s_11, s_12, s_22,
    output in_rdy, out_vld, out_beat, out_dout, singular, busy
  );
endinterface

// File: rtl/s_inv_2x2_div.sv
// ---------------------------------------------------------------------------
// s_inv_div
// Unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk, srst  clock, synchronous active-high reset
//   start      load dividend/divisor and begin (Q_W steps follow)
//   dividend   N_W-bit unsigned dividend (zero-extended to Q_W, N_W <= Q_W)
//   divisor    D_W-bit unsigned divisor, non-zero
//   done       high in the cycle whose closing edge performs the last step;
//              quotient is valid from that edge until the next start
//   quotient   Q_W-bit unsigned quotient
// ---------------------------------------------------------------------------
module s_inv_div #(
  parameter int N_W = 33,
  parameter int Q_W = 33,
  parameter int D_W = 64
) (
  input  logic           clk,
  input  logic           srst,
  input  logic           start,
  input  logic [N_W-1:0] dividend,
  input  logic [D_W-1:0] divisor,
  output logic           done,
  output logic [Q_W-1:0] quotient
);
  localparam int CNT_W = $clog2(Q_W + 1);

  // quo_reg shifts left: unconsumed dividend bits leave at the top while
  // quotient bits enter at the bottom.
  logic [Q_W-1:0]   quo_reg;
  logic [D_W-1:0]   rem_reg;
  logic [D_W-1:0]   dsr_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             active_reg;

  logic [D_W:0] trial;
  logic         fits;

  assign trial = {rem_reg, quo_reg[Q_W-1]};
  assign fits  = (trial >= {1'b0, dsr_reg});

  always_ff @(posedge clk) begin
    if (srst) begin
      quo_reg    <= '0;
      rem_reg    <= '0;
      dsr_reg    <= '0;
      cnt_reg    <= '0;
      active_reg <= 1'b0;
    end else if (start) begin
      quo_reg    <= Q_W'(dividend);
      rem_reg    <= '0;
      dsr_reg    <= divisor;
      cnt_reg    <= CNT_W'(Q_W);
      active_reg <= 1'b1;
    end else if (active_reg) begin
      rem_reg <= fits ? D_W'(trial - {1'b0, dsr_reg}) : trial[D_W-1:0];
      quo_reg <= {quo_reg[Q_W-2:0], fits};
      cnt_reg <= cnt_reg - CNT_W'(1);
      if (cnt_reg == CNT_W'(1)) active_reg <= 1'b0;
    end
  end

  assign done     = active_reg && (cnt_reg == CNT_W'(1));
  assign quotient = quo_reg;

endmodule

// File: rtl/s_inv_2x2.sv
// ---------------------------------------------------------------------------
// s_inv_2x2
// Sequential fixed-point inverse of the symmetric 2x2 innovation covariance
// S = [s_11 s_12; s_12 s_22]. Computes det, 1/det via a restoring divider,
// then streams S^-1 as three two-lane beats:
//   beat 0: {lane1=0,     lane0=inv11}
//   beat 1: {lane1=inv12, lane0=inv12}
//   beat 2: {lane1=inv22, lane0=0}
// A zero Q-format determinant flags singular and emits three zero beats.
// Ports:
//   clk      clock
//   sys_rst  synchronous active-high reset
//   bus      s_inv_2x2_if.slave (handshake, S elements, beats, status)
// Parameters: RSA_DW element width (<= 62), FRAC_W fractional bits.
// Config macro: S_INV_SAT_EN selects saturating (defined) or wrapping
// (undefined) reduction of each result to RSA_DW bits.
// ---------------------------------------------------------------------------
module s_inv_2x2
  import s_inv_2x2_pkg::*;
#(
  parameter int RSA_DW = 32,
  parameter int FRAC_W = 16
) (
  input logic         clk,
  input logic         sys_rst,
  s_inv_2x2_if.slave  bus
);
  localparam int N_W = 2 * FRAC_W + 1;   // holds 2^(2*FRAC_W)
  localparam int Q_W = RSA_DW + 1;       // reciprocal width
  localparam int P_W = 2 * RSA_DW;       // product / determinant width
  localparam int M_W = 2 * RSA_DW + 4;   // adj * recip, with headroom
  localparam logic [N_W-1:0] DIV_N = {1'b1, {(2 * FRAC_W){1'b0}}};

  s_inv_state_e             state_reg;
  logic signed [RSA_DW-1:0] s_11_reg, s_12_reg, s_22_reg;
  logic signed [P_W-1:0]    p1_reg, p2_reg;
  logic                     det_neg_reg;
  logic signed [RSA_DW-1:0] inv12_reg, inv22_reg;
  logic                     in_rdy_reg;
  logic                     out_vld_reg;
  logic [1:0]               out_beat_reg;
  logic [2*RSA_DW-1:0]      out_dout_reg;
  logic                     singular_reg;

  logic signed [P_W-1:0]    det_next;
  logic [P_W-1:0]           det_abs_next;
  logic                     div_start;
  logic                     div_done;
  logic [Q_W-1:0]           recip;

  // Adjugate entries, sign-extended one bit so -s_12 cannot overflow.
  logic signed [RSA_DW:0]   adj [3];
  logic [RSA_DW-1:0]        inv_next [3];

  // p1 - p2 cannot overflow P_W: it lies in [-2^(P_W-1), 2^(P_W-2)].
  always_comb begin
    det_next     = (p1_reg - p2_reg) >>> FRAC_W;
    det_abs_next = det_next[P_W-1] ? -det_next : det_next;
  end

  // The divider loads |det| on the same edge that leaves DET, so all
  // Q_W quotient steps land inside the DIV cycles.
  assign div_start = (state_reg == ST_DET) && (det_next != '0);

  s_inv_div #(
    .N_W (N_W),
    .Q_W (Q_W),
    .D_W (P_W)
  ) u_div (
    .clk      (clk),
    .srst     (sys_rst),
    .start    (div_start),
    .dividend (DIV_N),
    .divisor  (det_abs_next),
    .done     (div_done),
    .quotient (recip)
  );

  // (adj * recip) >>> FRAC_W, negated for a negative det, then reduced.
  function automatic logic [RSA_DW-1:0] scale_elem(
    input logic signed [RSA_DW:0] a,
    input logic [Q_W-1:0]         r,
    input logic                   neg
  );
    logic signed [M_W-1:0] prod;
    prod = M_W'(a) * $signed(M_W'(r));
    prod = prod >>> FRAC_W;
    if (neg) prod = -prod;
    return RSA_DW'(sat_reduce(SAT_W'(prod), RSA_DW));
  endfunction

  assign adj[0] = (RSA_DW + 1)'(s_22_reg);
  assign adj[1] = -((RSA_DW + 1)'(s_12_reg));
  assign adj[2] = (RSA_DW + 1)'(s_11_reg);

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_scale
      assign inv_next[gi] = scale_elem(adj[gi], recip, det_neg_reg);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_reg    <= ST_IDLE;
      s_11_reg     <= '0;
      s_12_reg     <= '0;
      s_22_reg     <= '0;
      p1_reg       <= '0;
      p2_reg       <= '0;
      det_neg_reg  <= 1'b0;
      inv12_reg    <= '0;
      inv22_reg    <= '0;
      in_rdy_reg   <= 1'b1;
      out_vld_reg  <= 1'b0;
      out_beat_reg <= BEAT_0;
      out_dout_reg <= '0;
      singular_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.in_vld) begin
            s_11_reg     <= bus.s_11;
            s_12_reg     <= bus.s_12;
            s_22_reg     <= bus.s_22;
            singular_reg <= 1'b0;
            in_rdy_reg   <= 1'b0;
            state_reg    <= ST_PROD;
          end
        end
        ST_PROD: begin
          p1_reg    <= P_W'(s_11_reg) * P_W'(s_22_reg);
          p2_reg    <= P_W'(s_12_reg) * P_W'(s_12_reg);
          state_reg <= ST_DET;
        end
        ST_DET: begin
          det_neg_reg <= det_next[P_W-1];
          if (det_next == '0) begin
            // Singular: skip the divider and stream three zero beats.
            singular_reg <= 1'b1;
            inv12_reg    <= '0;
            inv22_reg    <= '0;
            out_vld_reg  <= 1'b1;
            out_beat_reg <= BEAT_0;
            out_dout_reg <= '0;
            state_reg    <= ST_OUT0;
          end else begin
            state_reg <= ST_DIV;
          end
        end
        ST_DIV: begin
          if (div_done) state_reg <= ST_SCALE;
        end
        ST_SCALE: begin
          inv12_reg    <= inv_next[1];
          inv22_reg    <= inv_next[2];
          out_vld_reg  <= 1'b1;
          out_beat_reg <= BEAT_0;
          out_dout_reg <= {{RSA_DW{1'b0}}, inv_next[0]};
          state_reg    <= ST_OUT0;
        end
        ST_OUT0: begin
          out_beat_reg <= BEAT_1;
          out_dout_reg <= {inv12_reg, inv12_reg};
          state_reg    <= ST_OUT1;
        end
        ST_OUT1: begin
          out_beat_reg <= BEAT_2;
          out_dout_reg <= {inv22_reg, {RSA_DW{1'b0}}};
          state_reg    <= ST_OUT2;
        end
        ST_OUT2: begin
          out_vld_reg  <= 1'b0;
          out_beat_reg <= BEAT_0;
          out_dout_reg <= '0;
          in_rdy_reg   <= 1'b1;
          state_reg    <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_rdy   = in_rdy_reg;
  assign bus.busy     = ~in_rdy_reg;
  assign bus.out_vld  = out_vld_reg;
  assign bus.out_beat = out_beat_reg;
  assign bus.out_dout = out_dout_reg;
  assign bus.singular = singular_reg;

endmodule
